regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Shares the register file's single write port (A3/WD/WE) between two writeback requesters: source A (ALU writeback) and source B (load/memory writeback). Each source has a small in-order FIFO behind a valid/ready handshake. A round-robin arbiter drains the FIFOs into registered write-port outputs, and writes addressed to register $0 are suppressed. The block sits between the execute/memory stages and the register file, and is the only driver of the register file write port.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥2
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- a_valid  input  1  source A has a write
- a_ready  output  1  source A FIFO can accept
- a_addr  input  ADDR_W  source A destination register
- a_data  input  DATA_W  source A write data
- b_valid / b_ready / b_addr / b_data: same as A, for source B
- rf_we  output  1  register file write enable
- rf_a3  output  ADDR_W  register file write address
- rf_wd  output  DATA_W  register file write data
- idle  output  1  both FIFOs empty and rf_we low

## Operation
- **Accept:** a transfer on a source occurs at a rising edge where valid && ready. {addr, data} is pushed into that source's FIFO.
- **Ready:** x_ready = !full(x), computed from registered state only. A pop in the same cycle does not raise ready; there is no combinational valid→ready path.
- **Arbitration:** evaluated every cycle on FIFO-head status.
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: that source is granted.
  - Both non-empty: the source ≠ last_grant is granted.
  - last_grant updates on every grant. Its reset value is B, so A wins the first tie.
- **Pop:** the granted FIFO pops its head at the same edge. The head loads into rf_a3/rf_wd.
  - rf_we is set to 1 if the head address ≠ 0, else 0. A $0 write is consumed and dropped.
  - With no grant, rf_we is set to 0. rf_a3/rf_wd hold their previous values.
- **Ordering:** per-source order is preserved. Cross-source order to the same register follows grant order; upstream hazard logic owns correctness there.
- **FIFO:** circular buffer with read/write pointers of width log2(FIFO_DEPTH) plus one wrap bit.
  - full = pointers equal except for the wrap bit; empty = pointers fully equal.
  - Pointers wrap modulo 2·FIFO_DEPTH.
  - Simultaneous push and pop on a non-full FIFO is legal; occupancy stays the same.
- **Arbiter states** (the last_grant bit): GA (last grant was A) and GB (last grant was B).
  - A grant to A moves to GA; a grant to B moves to GB.
  - No grant: the state holds.

## Timing
- **Reset values (asynchronous, immediate):**
  - rf_we=0, rf_a3=0, rf_wd=0.
  - FIFOs empty (a_ready=b_ready=1 once rst deasserts; 0 while rst is low).
  - last_grant=B, idle=1.
- **Latency:**
  - Accept at edge N → earliest rf_we=1 during cycle N+1 → register file write at edge N+2.
  - Contended entries add one cycle per preceding grant.
- **Throughput:** one register write per cycle sustained. Each source can push every cycle while its FIFO is not full.
- **Reset mid-operation:** all queued writes are discarded and rf_we drops at once. Nothing partial is written after rst deasserts.
- **Stability:** inputs must be stable only around the accepting edge. Valid may drop without a transfer; there is no hold requirement.
- **Outputs:** rf_* come directly from flops, with no combinational path from the a_*/b_* inputs.

## Structure
- The shared package (mips_pkg) holds the REG_ZERO address constant (0) and the src_t enum {SRC_A, SRC_B}, reused by the hazard unit.
- One sub-module: wb_fifo (parameterised DATA_W+ADDR_W wide, FIFO_DEPTH deep, push/pop/full/empty), instantiated twice.
- The arbiter, last_grant flop and output registers live in regfile_wr_arbiter itself.

## Test plan
- **Reset defaults:** assert rst low mid-stream with both FIFOs full → rf_we=0 and idle=1 immediately. After release: a_ready=b_ready=1, and the first tie goes to A.
- **Single-source write:** A writes {addr=5, data=0xDEADBEEF} at edge N → rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF in cycle N+1 → rf_we=0 in cycle N+2.
- **Round-robin tie:** both sources push every cycle (A: addrs 1,2,3; B: addrs 11,12,13) → rf_a3 sequence 1,11,2,12,3,13. No cycle has rf_we low while data is pending.
- **Zero-register suppression:** A writes addr=0, data=0x1234 → entry consumed, rf_we stays 0, and the next A entry (addr=7) appears one cycle later.
- **Backpressure:** hold B valid every cycle with the arbiter kept busy by A → b_ready falls after FIFO_DEPTH accepts. No entry is lost or duplicated; the B sequence arrives in order.
- **Simultaneous push/pop at full:** with FIFO A full, pop and assert a_valid in the same cycle → no accept that cycle (a_ready=0). The push is accepted the next cycle and occupancy never exceeds FIFO_DEPTH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: register-zero address and writeback source ids.
package mips_pkg;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order writeback FIFO: circular buffer with wrap-bit pointers.
module wb_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Extra wrap bit makes the pointers count modulo 2*Depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
module regfile_wr_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_a3_o,
  output logic [DATA_W-1:0] rf_wd_o,
  output logic              idle_o
);

  localparam int unsigned EntW = ADDR_W + DATA_W;

  logic            a_full, a_empty, b_full, b_empty;
  logic [EntW-1:0] a_head, b_head, head;
  logic            grant_a, grant_b;
  src_t            last_grant_q, last_grant_d;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

  // Ready is held low while in reset, otherwise driven purely by the FIFO pointers.
  assign a_ready_o = rst && !a_full;
  assign b_ready_o = rst && !b_full;

  wb_fifo #(
    .Width(EntW),
    .Depth(FIFO_DEPTH)
  ) u_fifo_a (
    .clk    (clk),
    .rst    (rst),
    .push_i (a_valid_i && a_ready_o),
    .wdata_i({a_addr_i, a_data_i}),
    .pop_i  (grant_a),
    .rdata_o(a_head),
    .full_o (a_full),
    .empty_o(a_empty)
  );

  wb_fifo #(
    .Width(EntW),
    .Depth(FIFO_DEPTH)
  ) u_fifo_b (
    .clk    (clk),
    .rst    (rst),
    .push_i (b_valid_i && b_ready_o),
    .wdata_i({b_addr_i, b_data_i}),
    .pop_i  (grant_b),
    .rdata_o(b_head),
    .full_o (b_full),
    .empty_o(b_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= SRC_B;
    else      last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_a)      last_grant_d = SRC_A;
    else if (grant_b) last_grant_d = SRC_B;
  end

  // On a tie the source that did not win last time is granted.
  always_comb begin
    grant_a = !a_empty && (b_empty || (last_grant_q == SRC_B));
    grant_b = !b_empty && !grant_a;
  end

  assign head = grant_a ? a_head : b_head;

  always_comb begin
    rf_we_d = 1'b0;
    rf_a3_d = rf_a3_q;
    rf_wd_d = rf_wd_q;
    if (grant_a || grant_b) begin
      rf_a3_d = head[EntW-1:DATA_W];
      rf_wd_d = head[DATA_W-1:0];
      rf_we_d = (head[EntW-1:DATA_W] != ADDR_W'(REG_ZERO));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_a3_q <= rf_a3_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_we_o = rf_we_q;
  assign rf_a3_o = rf_a3_q;
  assign rf_wd_o = rf_wd_q;
  assign idle_o  = a_empty && b_empty && !rf_we_q;

endmodule
